vp_bitmap_serializer: RTL

- Consumer end of the merged-bitmap interface (foreground/background/bitmap/enable) driven by the bitmap merge stage.
- Accepts one 16-pixel character/graphic row word per handshake, buffers it in a 1-entry holding register plus a shift register, and emits one 4-bit colour index per pixel_tick, MSB first.
- Sits between the merge stage and the palette/RGB output stage; flags underrun when the pixel stream starves.

---
 rtl/vp_bitmap_serializer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/vp_bitmap_serializer.sv
// Bitmap row serializer: takes one {fg, bg, bitmap} row word per handshake and
// emits one colour index per pixel_tick, MSB first, flagging underrun when starved.
module vp_bitmap_serializer #(
    parameter int                    PIXELS         = 16,
    parameter int                    COLOR_BITS     = 4,
    parameter logic [COLOR_BITS-1:0] UNDERRUN_COLOR = {COLOR_BITS{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COLOR_BITS-1:0] foreground,
    input  logic [COLOR_BITS-1:0] background,
    input  logic [PIXELS-1:0]     bitmap,
    input  logic                  enable,
    output logic                  ready,
    input  logic                  pixel_tick,
    input  logic                  line_start,
    output logic [COLOR_BITS-1:0] color,
    output logic                  color_valid,
    output logic                  underrun
);

    localparam int            CW         = $clog2(PIXELS + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(PIXELS);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};

    logic                  hold_full_r;
    logic [COLOR_BITS-1:0] hold_fg_r;
    logic [COLOR_BITS-1:0] hold_bg_r;
    logic [PIXELS-1:0]     hold_bits_r;

    logic [PIXELS-1:0]     shift_bits_r;
    logic [COLOR_BITS-1:0] shift_fg_r;
    logic [COLOR_BITS-1:0] shift_bg_r;
    logic [CW-1:0]         shift_count_r;

    logic [COLOR_BITS-1:0] color_r;
    logic                  color_valid_r;
    logic                  underrun_r;

    logic accept_s;
    logic count_zero_s;
    logic emit_s;
    logic starve_s;
    logic xfer_s;

    // A transfer on the last-pixel tick keeps back-to-back words gapless.
    assign ready        = !hold_full_r && !line_start;
    assign accept_s     = enable && ready;
    assign count_zero_s = (shift_count_r == COUNT_ZERO);
    assign emit_s       = pixel_tick && !line_start && !count_zero_s;
    assign starve_s     = pixel_tick && !line_start && count_zero_s;
    assign xfer_s       = hold_full_r && !line_start &&
                          (count_zero_s || (pixel_tick && (shift_count_r == COUNT_ONE)));

    // Holding register: one word of slack between the merge stage and the shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full_r <= 1'b0;
            hold_fg_r   <= {COLOR_BITS{1'b0}};
            hold_bg_r   <= {COLOR_BITS{1'b0}};
            hold_bits_r <= {PIXELS{1'b0}};
        end else if (line_start) begin
            hold_full_r <= 1'b0;
        end else if (accept_s) begin
            hold_full_r <= 1'b1;
            hold_fg_r   <= foreground;
            hold_bg_r   <= background;
            hold_bits_r <= bitmap;
        end else if (xfer_s) begin
            hold_full_r <= 1'b0;
        end else begin
            hold_full_r <= hold_full_r;
        end
    end

    // Shift register: count tracks pixels still to be shown from the current word.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_bits_r  <= {PIXELS{1'b0}};
            shift_fg_r    <= {COLOR_BITS{1'b0}};
            shift_bg_r    <= {COLOR_BITS{1'b0}};
            shift_count_r <= COUNT_ZERO;
        end else if (line_start) begin
            shift_count_r <= COUNT_ZERO;
        end else if (xfer_s) begin
            shift_bits_r  <= hold_bits_r;
            shift_fg_r    <= hold_fg_r;
            shift_bg_r    <= hold_bg_r;
            shift_count_r <= COUNT_FULL;
        end else if (emit_s) begin
            shift_bits_r  <= {shift_bits_r[PIXELS-2:0], 1'b0};
            shift_count_r <= shift_count_r - COUNT_ONE;
        end else begin
            shift_count_r <= shift_count_r;
        end
    end

    // Registered pixel output; colour holds between ticks, underrun is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            color_r       <= UNDERRUN_COLOR;
            color_valid_r <= 1'b0;
            underrun_r    <= 1'b0;
        end else if (line_start) begin
            color_r       <= UNDERRUN_COLOR;
            color_valid_r <= 1'b0;
            underrun_r    <= 1'b0;
        end else if (emit_s) begin
            color_r       <= shift_bits_r[PIXELS-1] ? shift_fg_r : shift_bg_r;
            color_valid_r <= 1'b1;
            underrun_r    <= 1'b0;
        end else if (starve_s) begin
            color_r       <= UNDERRUN_COLOR;
            color_valid_r <= 1'b0;
            underrun_r    <= 1'b1;
        end else begin
            underrun_r    <= 1'b0;
        end
    end

    assign color       = color_r;
    assign color_valid = color_valid_r;
    assign underrun    = underrun_r;

endmodule
